// File: rtl/fwd_hazard_pkg.sv
// Shared types, constants and helpers for the forwarding / load-use hazard unit.
package fwd_hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int FWD_SEL_RF = 0;

    // Ceiling log2, used to size the per-operand forwarding select fields.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Per-operand forwarding select: nearest writing producer stage wins, register 0 never forwards.
module fwd_sel_prio
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic [NUM_FWD-1:0]            reg_write,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] waddr,
    input  logic [REG_ADDR_W-1:0]         src_addr,
    output logic [SEL_W-1:0]              sel
);

    // Scan farthest to nearest so the lowest matching stage index overrides the rest.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (reg_write[k] && (waddr[k*REG_ADDR_W +: REG_ADDR_W] == src_addr) &&
                (src_addr != {REG_ADDR_W{1'b0}})) begin
                sel = SEL_W'(k + 1);
            end else begin
                sel = sel;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use stall controller with multi-cycle load latency.
// Optional stall statistics counter enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    localparam int SEL_W     = clog2(NUM_FWD + 1)
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [NUM_FWD-1:0]            fwd_reg_write,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_addr,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_valid,
    input  logic                          id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         id_ex_waddr,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall_pc,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic [31:0]                   stall_cycles
);

    state_t               state_r, state_s;
    logic [3:0]           cnt_r, cnt_s;
    logic [NUM_SRC-1:0]   match_s;
    logic                 hazard_s;
    logic                 stall_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
        fwd_sel_prio #(
            .NUM_FWD    (NUM_FWD),
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
        ) u_prio (
            .reg_write (fwd_reg_write),
            .waddr     (fwd_waddr),
            .src_addr  (ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .sel       (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    // Load-use detect: any source actually read by IF/ID matches the pending load destination.
    always_comb begin
        match_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            match_s[i] = id_src_valid[i] && (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_waddr);
        end
        hazard_s = id_ex_mem_read && (id_ex_waddr != {REG_ADDR_W{1'b0}}) && (|match_s);
    end

    // Stall request; flush kills it in the same cycle regardless of state.
    always_comb begin
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ((state_r == RUN) && hazard_s) || (state_r == STALL);
        end
    end

    assign stall_pc     = stall_s;
    assign stall_if_id  = stall_s;
    assign bubble_id_ex = stall_s;

    // Next-state logic: the detect cycle counts as the first stall cycle, STALL covers the rest.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (flush) begin
            state_s = RUN;
            cnt_s   = 4'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s && (LOAD_LAT > 1)) begin
                        state_s = STALL;
                        cnt_s   = 4'(LOAD_LAT - 1);
                    end else begin
                        state_s = RUN;
                        cnt_s   = 4'd0;
                    end
                end
                STALL: begin
                    if (cnt_r <= 4'd1) begin
                        state_s = RUN;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = STALL;
                        cnt_s   = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_s = RUN;
                    cnt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stats_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stats_r <= 32'd0;
        end else if (stall_s && (stats_r != 32'hFFFF_FFFF)) begin
            stats_r <= stats_r + 32'd1;
        end
    end

    assign stall_cycles = stats_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=1 and LOAD_LAT=3) share directed stimulus.
module tb_fwd_hazard_unit;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [1:0]  fwd_reg_write;
    logic [9:0]  fwd_waddr;
    logic [9:0]  ex_src_addr;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_valid;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_waddr;
    logic        flush;

    logic [3:0]  sel1, sel3;
    logic        pc1, ifid1, bub1, pc3, ifid3, bub3;
    logic [31:0] cyc1, cyc3;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.LOAD_LAT(1)) dut1 (
        .clk(clk), .arst_n(arst_n), .fwd_reg_write(fwd_reg_write), .fwd_waddr(fwd_waddr),
        .ex_src_addr(ex_src_addr), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_waddr(id_ex_waddr), .flush(flush),
        .fwd_sel(sel1), .stall_pc(pc1), .stall_if_id(ifid1), .bubble_id_ex(bub1),
        .stall_cycles(cyc1)
    );

    fwd_hazard_unit #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .arst_n(arst_n), .fwd_reg_write(fwd_reg_write), .fwd_waddr(fwd_waddr),
        .ex_src_addr(ex_src_addr), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_waddr(id_ex_waddr), .flush(flush),
        .fwd_sel(sel3), .stall_pc(pc3), .stall_if_id(ifid3), .bubble_id_ex(bub3),
        .stall_cycles(cyc3)
    );

    typedef struct {
        int          tag;
        int          lat;
        int          field;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

`ifdef FWD_HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    function automatic void expect_val(input int tag, input int lat, input int field, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.lat = lat; e.field = field; e.val = val;
        q.push_back(e);
    endfunction

    // Field 0 = fwd_sel, 1 = all three stall outputs, 2 = stall_cycles.
    function automatic void expect_both(input int tag, input int field, input logic [31:0] v1, input logic [31:0] v3);
        expect_val(tag, 1, field, v1);
        expect_val(tag, 3, field, v3);
    endfunction

    // Monitor: compare every pending expectation against the outputs away from the active edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            string       fname;
            e = q.pop_front();
            case (e.field)
                0: begin fname = "fwd_sel";      act = (e.lat == 1) ? {28'd0, sel1} : {28'd0, sel3}; end
                1: begin fname = "stall";        act = (e.lat == 1) ? {29'd0, pc1, ifid1, bub1} : {29'd0, pc3, ifid3, bub3}; end
                default: begin fname = "stall_cycles"; act = (e.lat == 1) ? cyc1 : cyc3; end
            endcase
            if (e.field == 1) begin
                e.val = e.val[0] ? 32'd7 : 32'd0;
            end
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s step=%0d lat=%0d actual=%0h required=%0h", fname, e.tag, e.lat, act, e.val);
            end
        end
    end

    // Watchdog: abort with a failure if the stimulus never completes.
    initial begin
        #20000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: watchdog expired before the stimulus completed");
            $finish;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input logic [1:0] we, input logic [4:0] w1, input logic [4:0] w0,
                           input logic [4:0] s1, input logic [4:0] s0);
        fwd_reg_write = we;
        fwd_waddr     = {w1, w0};
        ex_src_addr   = {s1, s0};
    endtask

    task automatic set_load(input logic rd, input logic [1:0] vld, input logic fl);
        id_ex_mem_read = rd;
        id_ex_waddr    = 5'd7;
        id_src_addr    = {5'd7, 5'd2};
        id_src_valid   = vld;
        flush          = fl;
    endtask

    initial begin
        arst_n = 1'b0;
        set_fwd(2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
        set_load(1'b0, 2'b00, 1'b0);

        next_cycle();
        checks++;
        if ((pc1 !== 1'b0) || (ifid1 !== 1'b0) || (bub1 !== 1'b0) ||
            (pc3 !== 1'b0) || (ifid3 !== 1'b0) || (bub3 !== 1'b0) ||
            (cyc1 !== 32'd0) || (cyc3 !== 32'd0) || (sel1 !== 4'd0) || (sel3 !== 4'd0)) begin
            errors++;
            $display("FAIL reset state: stall=%b%b%b/%b%b%b cycles=%0h/%0h sel=%0h/%0h",
                     pc1, ifid1, bub1, pc3, ifid3, bub3, cyc1, cyc3, sel1, sel3);
        end
        expect_both(0, 0, 32'd0, 32'd0);
        expect_both(0, 1, 32'd0, 32'd0);
        expect_both(0, 2, 32'd0, 32'd0);
        next_cycle();
        arst_n = 1'b1;

        // Forwarding priority and register-0 exclusion.
        next_cycle(); set_fwd(2'b11, 5'd5, 5'd5, 5'd3, 5'd5); expect_both(1, 0, 32'h1, 32'h1);
        next_cycle(); set_fwd(2'b10, 5'd5, 5'd5, 5'd3, 5'd5); expect_both(2, 0, 32'h2, 32'h2);
        next_cycle(); set_fwd(2'b11, 5'd0, 5'd0, 5'd0, 5'd0); expect_both(3, 0, 32'h0, 32'h0);
        next_cycle(); set_fwd(2'b11, 5'd9, 5'd3, 5'd3, 5'd9); expect_both(4, 0, 32'h6, 32'h6);
        next_cycle(); set_fwd(2'b01, 5'd9, 5'd3, 5'd9, 5'd4); expect_both(5, 0, 32'h0, 32'h0);
        set_fwd(2'b00, 5'd0, 5'd0, 5'd0, 5'd0);

        // Load-use: unused source, then a real hazard.
        next_cycle(); set_load(1'b1, 2'b00, 1'b0); expect_both(6, 1, 32'd0, 32'd0);
        next_cycle(); set_load(1'b1, 2'b10, 1'b0); expect_both(7, 1, 32'd1, 32'd1);
        next_cycle(); set_load(1'b0, 2'b10, 1'b0); expect_both(8, 1, 32'd0, 32'd1);
        next_cycle();                               expect_both(9, 1, 32'd0, 32'd1);
        next_cycle();                               expect_both(10, 1, 32'd0, 32'd0);
        expect_both(10, 2, STATS ? 32'd1 : 32'd0, STATS ? 32'd3 : 32'd0);

        // Back-to-back load re-detect, then flush in the second stall cycle.
        next_cycle(); set_load(1'b1, 2'b10, 1'b0); expect_both(11, 1, 32'd1, 32'd1);
        next_cycle(); set_load(1'b0, 2'b10, 1'b0); expect_both(12, 1, 32'd0, 32'd1);
        next_cycle();                               expect_both(13, 1, 32'd0, 32'd1);
        next_cycle(); set_load(1'b1, 2'b10, 1'b0); expect_both(14, 1, 32'd1, 32'd1);
        next_cycle(); set_load(1'b0, 2'b10, 1'b1); expect_both(15, 1, 32'd0, 32'd0);
        next_cycle(); set_load(1'b0, 2'b10, 1'b0); expect_both(16, 1, 32'd0, 32'd0);

        // Flush in the detect cycle suppresses the whole sequence.
        next_cycle(); set_load(1'b1, 2'b10, 1'b1); expect_both(17, 1, 32'd0, 32'd0);
        next_cycle(); set_load(1'b0, 2'b10, 1'b0); expect_both(18, 1, 32'd0, 32'd0);
        expect_both(18, 2, STATS ? 32'd3 : 32'd0, STATS ? 32'd7 : 32'd0);

        // Asynchronous reset while the LOAD_LAT=3 instance sits in STALL.
        next_cycle(); set_load(1'b1, 2'b10, 1'b0); expect_both(19, 1, 32'd1, 32'd1);
        next_cycle(); set_load(1'b0, 2'b10, 1'b0); expect_both(20, 1, 32'd0, 32'd1);
        next_cycle(); arst_n = 1'b0;
        expect_both(21, 1, 32'd0, 32'd0);
        expect_both(21, 2, 32'd0, 32'd0);
        next_cycle(); arst_n = 1'b1;
        expect_both(22, 1, 32'd0, 32'd0);
        next_cycle(); set_load(1'b1, 2'b01, 1'b0); expect_both(23, 1, 32'd0, 32'd0);

        next_cycle();
        next_cycle();
        done = 1'b1;
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined core.
- Generalises operand forwarding to NUM_SRC source operands and NUM_FWD producer stages, with nearest-stage priority and register-0 exclusion.
- Adds a sequential load-use stall controller that supports multi-cycle load latency and flush abort.
- Sits beside the ID/EX pipeline register. It drives the ALU operand muxes, PC/IF-ID hold and the ID/EX bubble insertion.

Parameters:
- NUM_SRC, 2, number of source operands per instruction.
- NUM_FWD, 2, number of forwarding producer stages; stage 0 is nearest (EX/MEM), stage 1 is MEM/WB, and so on.
- REG_ADDR_W, 5, register address width.
- LOAD_LAT, 1, load-use stall cycles required, 1..15.
- SEL_W (localparam), $clog2(NUM_FWD+1), width of each select field.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  asynchronous reset, active-low.
- fwd_reg_write  in  NUM_FWD  write-enable of each producer stage.
- fwd_waddr  in  NUM_FWD*REG_ADDR_W  destination of each producer; stage k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- ex_src_addr  in  NUM_SRC*REG_ADDR_W  source registers of the instruction in ID/EX.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  source registers of the instruction in IF/ID.
- id_src_valid  in  NUM_SRC  source actually read by the IF/ID instruction.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- id_ex_waddr  in  REG_ADDR_W  ID/EX load destination.
- flush  in  1  taken branch/jump; kills younger instructions.
- fwd_sel  out  NUM_SRC*SEL_W  per-operand mux select.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID.
- bubble_id_ex  out  1  zero ID/EX control.
- stall_cycles  out  32  stall statistics (see Optional Feature).

Behaviour:
- Forwarding (combinational) for each operand i:
  - fwd_sel[i] = k+1 for the lowest k where fwd_reg_write[k]==1, fwd_waddr[k]==ex_src_addr[i] and ex_src_addr[i]!=0.
  - Otherwise fwd_sel[i] = 0, meaning the register file value.
  - Comparisons are unsigned; X in the inputs must not be masked (use ==, not !==).
- Load-use detect (combinational): hazard = id_ex_mem_read && id_ex_waddr!=0 && any i with id_src_valid[i] && id_src_addr[i]==id_ex_waddr.
- FSM states: RUN and STALL, with a 4-bit counter cnt.
  - RUN: if hazard && !flush, stall this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; else stay in RUN.
  - STALL: stall asserted. cnt decrements each cycle. When cnt==1, go to RUN next cycle.
  - Total stall length = LOAD_LAT cycles from the detect cycle.
- stall_pc = stall_if_id = bubble_id_ex = (state==RUN && hazard && !flush) || state==STALL.
- flush priority: flush in any state forces all three stall outputs to 0 in the same cycle. FSM goes to RUN with cnt=0 at the next edge.
- Hazard re-detected in RUN immediately after STALL exits (back-to-back loads) starts a fresh stall sequence.
- Reset: async clear to state RUN, cnt=0, stall_cycles=0. Stall outputs are then 0 unless hazard is asserted. fwd_sel is purely combinational. Reset mid-stall aborts the stall immediately.
- No latency on fwd_sel or the stall outputs; only the FSM state is registered.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined: stall_cycles increments on every cycle stall_pc==1, saturating at 32'hFFFF_FFFF and clearing on reset.
- Undefined: no counter logic; stall_cycles is tied to 0.

Decomposition:
- Package fwd_hazard_pkg holds:
  - state enum {RUN, STALL};
  - FWD_SEL_RF=0 constant;
  - sel-width function clog2 used for SEL_W.
- One sub-module, fwd_sel_prio: a per-operand priority comparator over NUM_FWD stages. It is instantiated NUM_SRC times by generate.

Test Plan:
- Forward priority: fwd_reg_write=2'b11, fwd_waddr={5,5}, ex_src_addr[0]=5 -> fwd_sel[0]=1 (stage 0 wins). With fwd_reg_write=2'b10 -> fwd_sel[0]=2.
- Register 0: fwd_reg_write=2'b11, fwd_waddr={0,0}, ex_src_addr={0,0} -> fwd_sel=0 for both operands.
- Load-use, LOAD_LAT=1: id_ex_mem_read=1, id_ex_waddr=7, id_src_addr[1]=7, id_src_valid=2'b10 -> stalls high exactly 1 cycle. With id_src_valid=2'b00 -> no stall.
- Load-use, LOAD_LAT=3: same stimulus -> stalls high 3 consecutive cycles, state sequence RUN, STALL(cnt 2), STALL(cnt 1), RUN.
- Flush mid-stall, LOAD_LAT=3: assert flush in the 2nd stall cycle -> stalls drop in that cycle; RUN next edge.
- Async reset during STALL; with FWD_HAZARD_STATS_EN, stall_cycles=3 after the previous test -> arst_n low gives immediate stall outputs 0, stall_cycles=0, state RUN.
